// File: rtl/usb_rx_timer_pkg.sv
// usb_rx_timer_pkg: shared types and default constants
// for the USB receive bit-timing sequencer.
package usb_rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } rx_timer_state_t;

  localparam int DEF_CLKS_PER_BIT  = 8;
  localparam int DEF_SAMPLE_PHASE  = 3;
  localparam int DEF_BITS_PER_BYTE = 8;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_rx_timer_sync_counter.sv
// sync_counter: generic wrap-at-value counter with
// synchronous clear, load and count enable.
module sync_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] wrap_val,
  output logic [W-1:0] count
);

  // clear beats load beats count; wrap is an explicit compare
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (count == wrap_val) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_timer.sv
// usb_rx_timer: aligns to the first bus edge, then emits
// mid-bit strobes and byte_done. Option: RX_TIMER_RESYNC_EN.
module usb_rx_timer
  import usb_rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE  = DEF_SAMPLE_PHASE,
  parameter int BITS_PER_BYTE = DEF_BITS_PER_BYTE,
  localparam int BW = clog2_min1(BITS_PER_BYTE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          abort,
  input  logic          d_edge,
  output logic          active,
  output logic          shift_strobe,
  output logic          byte_done,
  output logic [BW-1:0] bit_idx
);

  localparam int PW = clog2_min1(CLKS_PER_BIT);

  localparam logic [PW-1:0] PH_WRAP = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SMP  = PW'(SAMPLE_PHASE);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [BW-1:0] BT_WRAP = BW'(BITS_PER_BYTE - 1);

  rx_timer_state_t state_q;
  rx_timer_state_t state_d;

  logic [PW-1:0] phase;
  logic [BW-1:0] bit_cnt;
  logic          ph_load;
  logic          cnt_clr;
  logic          resync;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: abort > enable low > d_edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!abort && enable) state_d = ARM;
      end
      ARM: begin
        if (abort || !enable) state_d = IDLE;
        else if (d_edge)      state_d = RUN;
      end
      RUN: begin
        if (abort || !enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RX_TIMER_RESYNC_EN
  assign resync = (state_q == RUN) && (state_d == RUN) && d_edge;
`else
  assign resync = 1'b0;
`endif

  assign cnt_clr = (state_d != RUN);
  assign ph_load = ((state_q == ARM) && (state_d == RUN)) || resync;

  sync_counter #(.W(PW)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (ph_load),
    .load_val (PH_ONE),
    .en       (state_q == RUN),
    .wrap_val (PH_WRAP),
    .count    (phase)
  );

  sync_counter #(.W(BW)) u_bit (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (shift_strobe),
    .wrap_val (BT_WRAP),
    .count    (bit_cnt)
  );

  assign active       = (state_q == RUN);
  assign shift_strobe = active && (phase == PH_SMP);
  assign byte_done    = shift_strobe && (bit_cnt == BT_WRAP);
  assign bit_idx      = bit_cnt;

endmodule

// File: tb/tb_usb_rx_timer.sv
// tb_usb_rx_timer: directed checks of usb_rx_timer,
// default and (5,2,3) parameter sets.
module tb_usb_rx_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       en1 = 1'b0;
  logic       ab1 = 1'b0;
  logic       de1 = 1'b0;
  logic       act1;
  logic       stb1;
  logic       bd1;
  logic [2:0] bi1;

  logic       en2 = 1'b0;
  logic       ab2 = 1'b0;
  logic       de2 = 1'b0;
  logic       act2;
  logic       stb2;
  logic       bd2;
  logic [1:0] bi2;

  int n_checks = 0;
  int n_fail   = 0;

  usb_rx_timer dut1 (
    .clk          (clk),
    .rst          (rst),
    .enable       (en1),
    .abort        (ab1),
    .d_edge       (de1),
    .active       (act1),
    .shift_strobe (stb1),
    .byte_done    (bd1),
    .bit_idx      (bi1)
  );

  usb_rx_timer #(
    .CLKS_PER_BIT  (5),
    .SAMPLE_PHASE  (2),
    .BITS_PER_BYTE (3)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .enable       (en2),
    .abort        (ab2),
    .d_edge       (de2),
    .active       (act2),
    .shift_strobe (stb2),
    .byte_done    (bd2),
    .bit_idx      (bi2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en1 = 1'b0;
    en2 = 1'b0;
    de1 = 1'b0;
    de2 = 1'b0;
    ab1 = 1'b0;
    ab2 = 1'b0;
    step();
    step();
  endtask

  // enter ARM, then pulse d_edge; returns in cycle t+1
  task automatic start_dut1();
    en1 = 1'b1;
    step();
    de1 = 1'b1;
    step();
    de1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (act1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_active got %b want 0", act1);
    end
    n_checks++;
    if (stb1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobe got %b want 0", stb1);
    end
    n_checks++;
    if (bd1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_byte_done got %b want 0", bd1);
    end
    n_checks++;
    if (bi1 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_bit_idx got %0d want 0", bi1);
    end
    n_checks++;
    if (act2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_active2 got %b want 0", act2);
    end
  endtask

  // nominal byte, 20 continuous bits, then abort on a strobe
  task automatic test_nominal_continuous_abort();
    logic       e_stb;
    logic       e_bd;
    logic [2:0] e_bi;
    en1 = 1'b1;
    de1 = 1'b1;
    step();
    de1 = 1'b0;
    n_checks++;
    if (act1 !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_edge_ignored got %b want 0", act1);
    end
    de1 = 1'b1;
    n_checks++;
    if (act1 !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_active got %b want 0", act1);
    end
    step();
    de1 = 1'b0;
    for (int k = 1; k <= 155; k++) begin
      e_stb = (k >= 3) && (((k - 3) % 8) == 0);
      e_bd  = (k == 59) || (k == 123);
      e_bi  = 3'(((k - 3) / 8) % 8);
      n_checks++;
      if (act1 !== 1'b1) begin
        n_fail++;
        $display("FAIL run_active k=%0d got %b want 1", k, act1);
      end
      n_checks++;
      if (stb1 !== e_stb) begin
        n_fail++;
        $display("FAIL strobe k=%0d got %b want %b", k, stb1, e_stb);
      end
      n_checks++;
      if (bd1 !== e_bd) begin
        n_fail++;
        $display("FAIL byte_done k=%0d got %b want %b", k, bd1, e_bd);
      end
      if (e_stb) begin
        n_checks++;
        if (bi1 !== e_bi) begin
          n_fail++;
          $display("FAIL bit_idx k=%0d got %0d want %0d", k, bi1, e_bi);
        end
      end
      step();
    end
    for (int k = 156; k < 163; k++) step();
    ab1 = 1'b1;
    n_checks++;
    if (stb1 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_strobe got %b want 1", stb1);
    end
    n_checks++;
    if (bi1 !== 3'd4) begin
      n_fail++;
      $display("FAIL abort_bit_idx got %0d want 4", bi1);
    end
    step();
    ab1 = 1'b0;
    n_checks++;
    if (act1 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_exit got %b want 0", act1);
    end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (stb1 !== 1'b0 || act1 !== 1'b0) begin
        n_fail++;
        $display("FAIL post_abort k=%0d got %b%b want 00", k, act1, stb1);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    start_dut1();
    for (int k = 1; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    de1 = 1'b1;
    n_checks++;
    if ({act1, stb1, bd1, bi1} !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset got %b%b%b%0d want 0000",
               act1, stb1, bd1, bi1);
    end
    step();
    de1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (act1 !== 1'b0 || stb1 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_edge k=%0d got %b%b want 00",
                 k, act1, stb1);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_enable_drop();
    start_dut1();
    step();
    en1 = 1'b0;
    n_checks++;
    if (act1 !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_before got %b want 1", act1);
    end
    step();
    n_checks++;
    if (act1 !== 1'b0 || bi1 !== 3'd0) begin
      n_fail++;
      $display("FAIL enable_drop got %b/%0d want 0/0", act1, bi1);
    end
    go_idle();
  endtask

  task automatic test_resync();
    logic e_stb;
    int   want_k;
`ifdef RX_TIMER_RESYNC_EN
    want_k = 9;
`else
    want_k = 11;
`endif
    start_dut1();
    for (int k = 1; k < 6; k++) step();
    de1 = 1'b1;
    step();
    de1 = 1'b0;
    for (int k = 7; k <= 12; k++) begin
      e_stb = (k == want_k);
      n_checks++;
      if (stb1 !== e_stb) begin
        n_fail++;
        $display("FAIL resync k=%0d got %b want %b", k, stb1, e_stb);
      end
      if (e_stb) begin
        n_checks++;
        if (bi1 !== 3'd1) begin
          n_fail++;
          $display("FAIL resync_bit got %0d want 1", bi1);
        end
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_params();
    logic       e_stb;
    logic       e_bd;
    logic [1:0] e_bi;
    en2 = 1'b1;
    step();
    de2 = 1'b1;
    step();
    de2 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      e_stb = (k == 2) || (k == 7) || (k == 12);
      e_bd  = (k == 12);
      e_bi  = 2'((k - 2) / 5);
      n_checks++;
      if (stb2 !== e_stb) begin
        n_fail++;
        $display("FAIL p_strobe k=%0d got %b want %b", k, stb2, e_stb);
      end
      n_checks++;
      if (bd2 !== e_bd) begin
        n_fail++;
        $display("FAIL p_byte_done k=%0d got %b want %b", k, bd2, e_bd);
      end
      if (e_stb) begin
        n_checks++;
        if (bi2 !== e_bi) begin
          n_fail++;
          $display("FAIL p_bit_idx k=%0d got %0d want %0d", k, bi2, e_bi);
        end
      end
      step();
    end
    n_checks++;
    if (bi2 !== 2'd0) begin
      n_fail++;
      $display("FAIL p_bit_wrap got %0d want 0", bi2);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_nominal_continuous_abort();
    test_reset_mid();
    test_enable_drop();
    test_resync();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
